// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Debounces N_BTN independent active-low push buttons. Each raw pin passes
//   through a two-flop synchronizer, then a per-channel FSM that accepts a
//   level change only after DEBOUNCE_CYCLES consecutive stable samples. The
//   FSM also measures how long a button stays pressed and emits a single
//   long-press strobe once LONG_CYCLES pressed cycles have accumulated.
//
// Parameters
//   N_BTN            number of button channels
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a change
//   LONG_CYCLES      pressed cycles before a long-press strobe
//
// Ports
//   clk            in   system clock, rising-edge
//   reset          in   synchronous active-high reset
//   btn_raw_n      in   raw asynchronous button pins, 0 = pressed
//   db_n           out  registered debounced level, 0 = pressed
//   press_pulse    out  one-cycle strobe per accepted press
//   release_pulse  out  one-cycle strobe per accepted release
//   long_pulse     out  one-cycle strobe when a press reaches LONG_CYCLES
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] db_n,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    // Counter widths sized to hold their maximum value, so they never wrap.
    localparam int DB_W   = $clog2(64'(DEBOUNCE_CYCLES) + 64'd1);
    localparam int HOLD_W = $clog2(64'(LONG_CYCLES) + 64'd1);

    localparam logic [DB_W-1:0]   DB_LIMIT      = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_ONE        = DB_W'(32'd1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT    = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT_M1 = HOLD_W'(LONG_CYCLES - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_ONE      = HOLD_W'(32'd1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    // Two-flop synchronizer; idles at 1 (released) so reset never fakes a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_raw_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e             state_q, state_d;
        logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
        logic [HOLD_W-1:0]  hold_q, hold_d;
        logic               db_n_q, db_n_d;
        logic               press_q, press_d;
        logic               release_q, release_d;
        logic               long_q, long_d;
        logic               s2_s;

        assign s2_s = sync2_q[i];

        // Next-state and next-output logic for one channel.
        always_comb begin
            state_d   = state_q;
            db_cnt_d  = db_cnt_q;
            hold_d    = hold_q;
            db_n_d    = db_n_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    if (!s2_s) begin
                        state_d  = ST_PRESS_WAIT;
                        db_cnt_d = DB_ONE;
                    end else begin
                        state_d  = ST_RELEASED;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (s2_s) begin
                        // Bounce: drop back silently.
                        state_d = ST_RELEASED;
                    end else if (db_cnt_q < DB_LIMIT) begin
                        db_cnt_d = db_cnt_q + DB_ONE;
                    end else begin
                        state_d = ST_PRESSED;
                        db_n_d  = 1'b0;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (s2_s) begin
                        state_d  = ST_RELEASE_WAIT;
                        db_cnt_d = DB_ONE;
                    end else if (hold_q < HOLD_LIMIT) begin
                        // Saturating at the limit means the strobe can only
                        // fire on the single 0..LIMIT crossing of this press.
                        hold_d = hold_q + HOLD_ONE;
                        long_d = (hold_q == HOLD_LIMIT_M1);
                    end else begin
                        hold_d = hold_q;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!s2_s) begin
                        // Glitch during release; hold count is preserved so
                        // the long strobe is not re-armed.
                        state_d = ST_PRESSED;
                    end else if (db_cnt_q < DB_LIMIT) begin
                        db_cnt_d = db_cnt_q + DB_ONE;
                    end else begin
                        state_d   = ST_RELEASED;
                        db_n_d    = 1'b1;
                        release_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    db_n_d  = 1'b1;
                end
            endcase
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= ST_RELEASED;
                db_cnt_q  <= '0;
                hold_q    <= '0;
                db_n_q    <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                hold_q    <= hold_d;
                db_n_q    <= db_n_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign db_n[i]          = db_n_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Directed stimulus for button_debouncer (N_BTN=4, DEBOUNCE_CYCLES=8,
//   LONG_CYCLES=40). Stimulus pushes expected events (cycle, pulses, db_n)
//   into a queue; an independent monitor pops and compares whenever the DUT
//   shows a pulse or a db_n change.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int LAT = 11; // DEBOUNCE_CYCLES + 3
    localparam int LNG = 40;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
        logic [3:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_raw_n = 4'hF;
    logic [3:0] db_n;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    ev_t  sb[$];
    logic [3:0] exp_db = 4'hF;

    button_debouncer #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES(40)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw_n(btn_raw_n),
        .db_n(db_n),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used as the time base for expected events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r,
                             input logic [3:0] l, input logic [3:0] d);
        ev_t e;
        e.cyc = at; e.p = p; e.r = r; e.l = l; e.d = d;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse or db_n change must match the head of the queue.
    initial begin
        ev_t e;
        logic [3:0] db_prev;
        db_prev = 4'hF;
        forever begin
            @(negedge clk);
            if (mon_en && (((press_pulse | release_pulse | long_pulse) != 4'h0) || (db_n !== db_prev))) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d press=%h release=%h long=%h db_n=%h",
                             cyc, press_pulse, release_pulse, long_pulse, db_n);
                end else begin
                    e = sb.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("press_pulse", 32'(press_pulse), 32'(e.p));
                    chk("release_pulse", 32'(release_pulse), 32'(e.r));
                    chk("long_pulse", 32'(long_pulse), 32'(e.l));
                    chk("db_n", 32'(db_n), 32'(e.d));
                end
            end
            db_prev = db_n;
        end
    end

    initial begin
        int k;
        // Reset state
        tick(3);
        chk("reset_db_n", 32'(db_n), 32'h0000_000F);
        chk("reset_press", 32'(press_pulse), 32'h0);
        chk("reset_release", 32'(release_pulse), 32'h0);
        chk("reset_long", 32'(long_pulse), 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(3);

        // Clean press and release on channel 0
        btn_raw_n[0] = 1'b0; k = cyc; exp_db[0] = 1'b0;
        expect_ev(k + LAT, 4'h1, 4'h0, 4'h0, exp_db);
        tick(20);
        btn_raw_n[0] = 1'b1; k = cyc; exp_db[0] = 1'b1;
        expect_ev(k + LAT, 4'h0, 4'h1, 4'h0, exp_db);
        tick(20);

        // Bounce on channel 1 that ends released: nothing may happen
        btn_raw_n[1] = 1'b0; tick(5);
        btn_raw_n[1] = 1'b1; tick(3);
        btn_raw_n[1] = 1'b0; tick(4);
        btn_raw_n[1] = 1'b1; tick(20);
        chk("bounce_db_n", 32'(db_n), 32'h0000_000F);
        // Same bounce, ending held low
        btn_raw_n[1] = 1'b0; tick(5);
        btn_raw_n[1] = 1'b1; tick(3);
        btn_raw_n[1] = 1'b0; k = cyc; exp_db[1] = 1'b0;
        expect_ev(k + LAT, 4'h2, 4'h0, 4'h0, exp_db);
        tick(20);
        btn_raw_n[1] = 1'b1; k = cyc; exp_db[1] = 1'b1;
        expect_ev(k + LAT, 4'h0, 4'h2, 4'h0, exp_db);
        tick(20);

        // Long press on channel 2, held 60 cycles
        btn_raw_n[2] = 1'b0; k = cyc; exp_db[2] = 1'b0;
        expect_ev(k + LAT, 4'h4, 4'h0, 4'h0, exp_db);
        expect_ev(k + LAT + LNG, 4'h0, 4'h0, 4'h4, exp_db);
        tick(60);
        btn_raw_n[2] = 1'b1; k = cyc; exp_db[2] = 1'b1;
        expect_ev(k + LAT, 4'h0, 4'h4, 4'h0, exp_db);
        tick(20);

        // Release bounce on channel 0
        btn_raw_n[0] = 1'b0; k = cyc; exp_db[0] = 1'b0;
        expect_ev(k + LAT, 4'h1, 4'h0, 4'h0, exp_db);
        tick(20);
        btn_raw_n[0] = 1'b1; tick(3);
        btn_raw_n[0] = 1'b0; tick(2);
        btn_raw_n[0] = 1'b1; k = cyc; exp_db[0] = 1'b1;
        expect_ev(k + LAT, 4'h0, 4'h1, 4'h0, exp_db);
        tick(20);

        // Simultaneous press and release on all channels
        btn_raw_n = 4'h0; k = cyc; exp_db = 4'h0;
        expect_ev(k + LAT, 4'hF, 4'h0, 4'h0, exp_db);
        tick(20);
        btn_raw_n = 4'hF; k = cyc; exp_db = 4'hF;
        expect_ev(k + LAT, 4'h0, 4'hF, 4'h0, exp_db);
        tick(20);

        // Reset while channel 3 is in PRESS_WAIT with counter 5
        btn_raw_n[3] = 1'b0;
        tick(7);
        reset = 1'b1;
        tick(1);
        reset = 1'b0; k = cyc; exp_db[3] = 1'b0;
        expect_ev(k + LAT, 4'h8, 4'h0, 4'h0, exp_db);
        tick(2);
        chk("reset_abort_db_n", 32'(db_n), 32'h0000_000F);
        tick(20);
        btn_raw_n[3] = 1'b1; k = cyc; exp_db[3] = 1'b1;
        expect_ev(k + LAT, 4'h0, 4'h8, 4'h0, exp_db);
        tick(25);

        chk("queue_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
